// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : fifo_rd_pkg                                                 |
// | Purpose  : Shared types and constants for the FIFO burst reader.       |
// |            Holds the reader FSM state encoding and the skid buffer     |
// |            geometry used by both the top and the skid sub-module.      |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    READ      = 2'd2,
    DRAIN     = 2'd3
  } rd_state_t;

  localparam int SKID_DEPTH = 2;
  // Occupancy counter must represent 0..SKID_DEPTH inclusive.
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int SKID_PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

endpackage : fifo_rd_pkg
`default_nettype wire

// File: rtl/reader_skid_buf.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : reader_skid_buf                                             |
// | Purpose  : Small SKID_DEPTH-entry FIFO of {last, data} that decouples  |
// |            the registered FIFO read port from the downstream stream    |
// |            handshake. Push and pop may happen in the same cycle.       |
// | Ports    : clk, reset (sync, active-low)                               |
// |            push/push_data/push_last : write one entry                  |
// |            pop                      : remove head (ignored when empty) |
// |            head_valid/head_data/head_last : current head entry         |
// |            occupancy                : number of stored entries         |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module reader_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  push_last,
  input  logic                  pop,
  output logic                  head_valid,
  output logic [DATA_W-1:0]     head_data,
  output logic                  head_last,
  output logic [SKID_CNT_W-1:0] occupancy
);

  localparam logic [SKID_PTR_W-1:0] LAST_PTR = SKID_PTR_W'(SKID_DEPTH - 1);

  // Entry layout: bit DATA_W is the last tag, lower bits are the data word.
  logic [DATA_W:0]          mem [SKID_DEPTH];
  logic [SKID_PTR_W-1:0]    wr_ptr;
  logic [SKID_PTR_W-1:0]    rd_ptr;
  logic [SKID_CNT_W-1:0]    count;
  logic                     do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  assign head_data  = mem[rd_ptr][DATA_W-1:0];
  assign head_last  = mem[rd_ptr][DATA_W];
  assign occupancy  = count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      // Clearing storage keeps the stream data output at zero after reset.
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {push_last, push_data};
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + SKID_PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + SKID_PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + SKID_CNT_W'(1);
        2'b01:   count <= count - SKID_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule : reader_skid_buf
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : fifo_burst_reader                                           |
// | Purpose  : Read-side master for a synchronous FIFO. On start it waits  |
// |            for a full burst (or a partial one under flush), pops the   |
// |            words and forwards them on a valid/ready stream, tagging    |
// |            the final word with m_last.                                 |
// | Ports    : clk, reset (sync, active-low)                               |
// |            start, flush             : burst control                    |
// |            fifo_count/empty/data    : FIFO status and read data        |
// |            fifo_r_en                : FIFO pop strobe                  |
// |            m_valid/m_ready/m_data/m_last : output stream               |
// |            busy, bursts_done        : status                           |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 4,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [CNT_W-1:0]  fifo_count,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_r_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [7:0]        bursts_done
);

  localparam int                ISS_W     = $clog2(BURST_LEN + 1);
  localparam logic [ISS_W-1:0]  BURST_ISS = ISS_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [SKID_CNT_W:0] SKID_LIMIT = (SKID_CNT_W + 1)'(SKID_DEPTH);

  rd_state_t             state;
  rd_state_t             state_next;
  logic [ISS_W-1:0]      issued;
  logic [ISS_W-1:0]      len;
  logic                  inflight;
  logic                  inflight_last;
  logic                  load_full;
  logic                  load_flush;

  logic                  head_valid;
  logic                  head_last;
  logic [DATA_W-1:0]     head_data;
  logic [SKID_CNT_W-1:0] occupancy;
  logic                  pop;
  logic [SKID_CNT_W:0]   committed;
  logic                  credit_ok;

  assign pop = head_valid && m_ready;

  // Skid slots already spoken for: stored words plus the read in flight,
  // minus the word leaving this cycle. Counting the departing word lets a
  // ready consumer receive one word per clock; the skid still cannot
  // overflow because every issued read is charged before its data lands.
  assign committed = (SKID_CNT_W + 1)'(occupancy)
                   + (SKID_CNT_W + 1)'(inflight)
                   - (SKID_CNT_W + 1)'(pop);
  assign credit_ok = !fifo_empty && (issued < len) && (committed < SKID_LIMIT);

  always_comb begin
    state_next = state;
    fifo_r_en  = 1'b0;
    load_full  = 1'b0;
    load_flush = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = WAIT_FILL;
      end
      WAIT_FILL: begin
        // Full-burst test has priority over flush.
        if (fifo_count >= BURST_CNT) begin
          state_next = READ;
          load_full  = 1'b1;
        end else if (flush && (fifo_count != '0)) begin
          state_next = READ;
          load_flush = 1'b1;
        end
      end
      READ: begin
        fifo_r_en = credit_ok;
        if (issued == len) state_next = DRAIN;
      end
      DRAIN: begin
        if (pop && head_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      issued        <= '0;
      len           <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      bursts_done   <= 8'd0;
    end else begin
      state         <= state_next;
      inflight      <= fifo_r_en;
      inflight_last <= fifo_r_en && (issued == len - ISS_W'(1));
      if (load_full) begin
        len    <= BURST_ISS;
        issued <= '0;
      end else if (load_flush) begin
        // Flush is only taken below a full burst, so the count fits ISS_W.
        len    <= ISS_W'(fifo_count);
        issued <= '0;
      end else if (fifo_r_en) begin
        issued <= issued + ISS_W'(1);
      end
      if ((state == DRAIN) && (state_next == IDLE)) begin
        bursts_done <= bursts_done + 8'd1;
      end
    end
  end

  // FIFO read data is registered, so the word is captured one cycle after
  // its pop strobe, together with the last tag computed at issue time.
  reader_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight),
    .push_data  (fifo_data),
    .push_last  (inflight_last),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head_data),
    .head_last  (head_last),
    .occupancy  (occupancy)
  );

  assign m_valid = head_valid;
  assign m_data  = head_data;
  assign m_last  = head_last;
  assign busy    = (state != IDLE);

endmodule : fifo_burst_reader
`default_nettype wire
